// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interrupt timer: FSM states,
// register window offsets, CTRL field positions and MODE encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] CTRL   = 2'd0;
  localparam logic [1:0] PRESET = 2'd1;
  localparam logic [1:0] COUNT  = 2'd2;

  localparam int EN      = 0;
  localparam int MODE_LO = 1;
  localparam int MODE_HI = 2;
  localparam int IM      = 3;

  localparam logic [1:0] ONESHOT = 2'd0;
  localparam logic [1:0] RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// Programmable 32-bit down-counter with CTRL/PRESET/COUNT register window
// and a registered, maskable interrupt request for CP0.
module timer_counter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        wr_ctrl, wr_preset;

  assign wr_ctrl   = we && (addr == CTRL);
  assign wr_preset = we && (addr == PRESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    // Bus writes first so the FSM below can override the acknowledge
    // (expiry set must win) without ever losing an interrupt.
    if (wr_ctrl) begin
      ctrl_d     = wdata[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = wdata;
      irq_flag_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_q[EN]) state_d = LOAD;
      end
      LOAD: begin
        if (ctrl_q[EN]) begin
          count_d = preset_q;
          state_d = CNT;
        end else begin
          state_d = IDLE;
        end
      end
      CNT: begin
        if (!ctrl_q[EN]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        state_d = IDLE;
        // Modes 2 and 3 fall into the one-shot branch; a concurrent CTRL
        // write keeps whatever EN software just wrote.
        if (ctrl_q[MODE_HI:MODE_LO] == RELOAD) begin
          irq_flag_d = 1'b0;
        end else if (!wr_ctrl) begin
          ctrl_d[EN] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      CTRL:    rdata = {28'd0, ctrl_q};
      PRESET:  rdata = preset_q;
      COUNT:   rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = ctrl_q[IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expectations are queued when stimulus is
// applied and popped against DUT outputs sampled at the falling edge.
module tb_timer_counter;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
      $display("chk %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    push(tag, exp);
    addr = a;
    #1;
    pop_chk(rdata);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    push(tag, {31'd0, exp});
    pop_chk({31'd0, irq});
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = CTRL;
    wdata = 32'd0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    chk_reg("rst_ctrl", CTRL, 32'd0);
    chk_reg("rst_preset", PRESET, 32'd0);
    chk_reg("rst_count", COUNT, 32'd0);
    chk_irq("rst_irq", 1'b0);

    // One-shot, PRESET = 3, IM = 1
    wr(PRESET, 32'd3);
    wr(CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k >= 2 && k <= 5) chk_reg($sformatf("os_count_e%0d", k), COUNT, 32'(5 - k));
      chk_irq($sformatf("os_irq_e%0d", k), k >= 5);
    end
    chk_reg("os_ctrl_done", CTRL, 32'h8);
    wr(PRESET, 32'd3);
    chk_irq("os_ack", 1'b0);

    // Auto-reload, PRESET = 2: pulse every 5 cycles
    wr(PRESET, 32'd2);
    wr(CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk_irq($sformatf("ar_irq_e%0d", k), (k >= 4) && (((k - 4) % 5) == 0));
    end
    wr(CTRL, 32'h0);
    cyc();
    cyc();

    // Masked one-shot, then unmask and restart
    wr(PRESET, 32'd1);
    wr(CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk_irq($sformatf("mask_irq_e%0d", k), 1'b0);
    end
    chk_reg("mask_ctrl", CTRL, 32'h0);
    chk_reg("mask_count", COUNT, 32'd0);
    wr(CTRL, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk_irq($sformatf("unmask_irq_e%0d", k), k == 3);
    end
    wr(CTRL, 32'h8);
    chk_irq("unmask_ack", 1'b0);

    // Pause mid-count and ignored accesses
    wr(PRESET, 32'd10);
    wr(CTRL, 32'h9);
    for (int k = 1; k <= 5; k++) cyc();
    chk_reg("pause_count7", COUNT, 32'd7);
    wr(CTRL, 32'h8);
    chk_reg("pause_count_w", COUNT, 32'd6);
    cyc();
    cyc();
    chk_reg("pause_frozen", COUNT, 32'd6);
    wr(COUNT, 32'h1234);
    wr(2'd3, 32'hFFFF);
    chk_reg("ign_count", COUNT, 32'd6);
    chk_reg("ign_off3", 2'd3, 32'd0);
    chk_reg("ign_preset", PRESET, 32'd10);
    wr(CTRL, 32'h9);
    cyc();
    cyc();
    chk_reg("reenable_load", COUNT, 32'd10);
    wr(CTRL, 32'h8);
    cyc();

    // PRESET write on the expiry edge: interrupt must not be lost
    wr(PRESET, 32'd2);
    wr(CTRL, 32'h9);
    for (int k = 1; k <= 3; k++) cyc();
    chk_reg("race_count1", COUNT, 32'd1);
    wr(PRESET, 32'd2);
    chk_irq("race_set_wins", 1'b1);
    cyc();
    chk_irq("race_hold", 1'b1);
    chk_reg("race_ctrl", CTRL, 32'h8);

    // CTRL write on the INT edge: written EN wins
    wr(CTRL, 32'h9);
    chk_irq("en_race_ack", 1'b0);
    for (int k = 1; k <= 3; k++) cyc();
    cyc();
    chk_irq("en_race_int", 1'b1);
    wr(CTRL, 32'h9);
    chk_reg("en_race_ctrl", CTRL, 32'h9);
    chk_irq("en_race_cleared", 1'b0);
    wr(CTRL, 32'h8);
    cyc();

    // Asynchronous reset mid-count
    wr(PRESET, 32'd10);
    wr(CTRL, 32'h9);
    for (int k = 1; k <= 7; k++) cyc();
    chk_reg("pre_rst_count", COUNT, 32'd5);
    #1 reset = 1'b1;
    chk_reg("arst_count", COUNT, 32'd0);
    chk_reg("arst_ctrl", CTRL, 32'd0);
    chk_reg("arst_preset", PRESET, 32'd0);
    chk_irq("arst_irq", 1'b0);
    cyc();
    reset = 1'b0;
    wr(PRESET, 32'd4);
    for (int k = 1; k <= 3; k++) cyc();
    chk_reg("post_rst_idle", COUNT, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
